// File: rtl/noc_pkg.sv
// Shared NoC router definitions for the side-buffer control path.
// Contents: side-buffer FSM state type, default sizing constants and a
// modular increment helper used for round-robin pointer updates.
package noc_pkg;

    localparam int unsigned NUM_PORT_DEF  = 4;  // pipeline slots N/E/S/W
    localparam int unsigned STARVE_TH_DEF = 8;  // mirrors SIDE_BUF_CNT_TH
    localparam int unsigned COOL_CYC_DEF  = 2;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        STARVE = 2'd1,
        COOL   = 2'd2
    } sb_state_e;

    // (idx + 1) mod n without a divider
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping mod N.
// Ports:
//   req  in   N    request vector
//   ptr  in   PW   starting position
//   gnt  out  N    one-hot grant (zero when no request)
//   idx  out  PW   index of the granted bit (zero when no request)
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    logic [PW-1:0] pos;
    logic          found;

    // scan N positions starting at ptr, keep the first hit
    always_comb begin
        gnt   = '0;
        idx   = '0;
        pos   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = PW'((32'(ptr) + k) % N);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/side_buf_ctrl.sv
// Control end of the MinBD side buffer. Each cycle decides whether to capture
// one deflected flit, reinject the buffer head into a free slot, or (when the
// buffer has starved) swap a network flit for the head.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   slot_vld            slot i holds a flit
//   deflect_req         slot i flit is a buffering candidate (subset of slot_vld)
//   sb_empty, sb_full   side-buffer status
//   deflect_to_sb_vld   write deflected flit, slot in deflect_sel (one-hot)
//   redirect_gnt        write redirected flit (swap), slot in redirect_sel (one-hot)
//   inject_gnt          pop buffer head, target slot in inject_sel (one-hot)
//   starve              FSM is in STARVE
// Outputs are combinational from registered state and current inputs.
module side_buf_ctrl
    import noc_pkg::*;
#(
    parameter int unsigned NUM_PORT  = NUM_PORT_DEF,
    parameter int unsigned STARVE_TH = STARVE_TH_DEF,
    parameter int unsigned COOL_CYC  = COOL_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PORT-1:0] slot_vld,
    input  logic [NUM_PORT-1:0] deflect_req,
    input  logic                sb_empty,
    input  logic                sb_full,
    output logic                deflect_to_sb_vld,
    output logic [NUM_PORT-1:0] deflect_sel,
    output logic                redirect_gnt,
    output logic [NUM_PORT-1:0] redirect_sel,
    output logic                inject_gnt,
    output logic [NUM_PORT-1:0] inject_sel,
    output logic                starve
);

    localparam int unsigned PW     = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
    localparam int unsigned CNT_W  = $clog2(STARVE_TH + 1);
    localparam int unsigned COOL_W = (COOL_CYC > 1) ? $clog2(COOL_CYC) : 1;

    sb_state_e          state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [PW-1:0]      rr_ptr, rr_ptr_nxt;
    logic [COOL_W-1:0]  cool_cnt, cool_cnt_nxt;

    logic [NUM_PORT-1:0] free;
    logic [NUM_PORT-1:0] free_lo;
    logic [NUM_PORT-1:0] dfl_gnt, red_gnt;
    logic [PW-1:0]       dfl_idx, red_idx;

    // slots vacated by a deflect this cycle are still occupied, so free is slot_vld only
    assign free    = ~slot_vld;
    assign free_lo = free & (~free + NUM_PORT'(1));

    rr_pick #(.N(NUM_PORT), .PW(PW)) u_dfl_pick (
        .req (deflect_req),
        .ptr (rr_ptr),
        .gnt (dfl_gnt),
        .idx (dfl_idx)
    );

    rr_pick #(.N(NUM_PORT), .PW(PW)) u_red_pick (
        .req (slot_vld),
        .ptr (rr_ptr),
        .gnt (red_gnt),
        .idx (red_idx)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= NORMAL;
            cnt      <= '0;
            rr_ptr   <= '0;
            cool_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rr_ptr   <= rr_ptr_nxt;
            cool_cnt <= cool_cnt_nxt;
        end
    end

    // next state: starvation counter, round-robin pointer and FSM
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rr_ptr_nxt   = rr_ptr;
        cool_cnt_nxt = cool_cnt;

        // a pop (including the pop half of a swap) restarts the count
        if (sb_empty || inject_gnt) begin
            cnt_nxt = '0;
        end else if (cnt != CNT_W'(STARVE_TH)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end

        if (deflect_to_sb_vld) begin
            rr_ptr_nxt = PW'(wrap_inc(32'(dfl_idx), NUM_PORT));
        end else if (redirect_gnt) begin
            rr_ptr_nxt = PW'(wrap_inc(32'(red_idx), NUM_PORT));
        end

        case (state)
            NORMAL: begin
                if (cnt_nxt == CNT_W'(STARVE_TH)) begin
                    state_nxt = STARVE;
                end
            end
            STARVE: begin
                if (redirect_gnt) begin
                    state_nxt    = COOL;
                    cool_cnt_nxt = COOL_W'(COOL_CYC - 1);
                end else if (inject_gnt || sb_empty) begin
                    state_nxt = NORMAL;
                end
            end
            COOL: begin
                if (cool_cnt == '0) begin
                    state_nxt = (cnt_nxt == CNT_W'(STARVE_TH)) ? STARVE : NORMAL;
                end else begin
                    cool_cnt_nxt = cool_cnt - COOL_W'(1);
                end
            end
            default: state_nxt = NORMAL;
        endcase
    end

    // per-cycle grants; everything held low during reset
    always_comb begin
        deflect_to_sb_vld = 1'b0;
        deflect_sel       = '0;
        redirect_gnt      = 1'b0;
        redirect_sel      = '0;
        inject_gnt        = 1'b0;
        inject_sel        = '0;
        starve            = 1'b0;
        if (!rst) begin
            starve = (state == STARVE);
            if ((|deflect_req) && !sb_full) begin
                deflect_to_sb_vld = 1'b1;
                deflect_sel       = dfl_gnt;
            end
            // a deflect uses the single write port, so it blocks the swap
            if ((state == STARVE) && !sb_empty && !sb_full && (free == '0) && !deflect_to_sb_vld) begin
                redirect_gnt = 1'b1;
                redirect_sel = red_gnt;
                inject_gnt   = 1'b1;
                inject_sel   = red_gnt;
            end else if (!sb_empty && (|free)) begin
                inject_gnt = 1'b1;
                inject_sel = free_lo;
            end
        end
    end

endmodule

// File: tb/tb_side_buf_ctrl.sv
// Directed testbench for side_buf_ctrl: a table of single-cycle decisions
// from a freshly reset state, plus hand-written multi-cycle sequences for
// round-robin advance, starvation, swap, cool-down and mid-run reset.
module tb_side_buf_ctrl;
    import noc_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] slot_vld;
    logic [3:0] deflect_req;
    logic       sb_empty;
    logic       sb_full;
    logic       deflect_to_sb_vld;
    logic [3:0] deflect_sel;
    logic       redirect_gnt;
    logic [3:0] redirect_sel;
    logic       inject_gnt;
    logic [3:0] inject_sel;
    logic       starve;
    logic [15:0] outs;

    int n_total;
    int n_pass;

    side_buf_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .slot_vld          (slot_vld),
        .deflect_req       (deflect_req),
        .sb_empty          (sb_empty),
        .sb_full           (sb_full),
        .deflect_to_sb_vld (deflect_to_sb_vld),
        .deflect_sel       (deflect_sel),
        .redirect_gnt      (redirect_gnt),
        .redirect_sel      (redirect_sel),
        .inject_gnt        (inject_gnt),
        .inject_sel        (inject_sel),
        .starve            (starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign outs = {deflect_to_sb_vld, deflect_sel, redirect_gnt, redirect_sel,
                   inject_gnt, inject_sel, starve};

    typedef struct packed {
        logic [3:0]  slot;
        logic [3:0]  defl;
        logic        empty;
        logic        full;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [15:0] eo(input logic dv, input logic [3:0] ds,
                                       input logic rg, input logic [3:0] rs,
                                       input logic ig, input logic [3:0] is,
                                       input logic st);
        return {dv, ds, rg, rs, ig, is, st};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic [3:0] s, input logic [3:0] d,
                         input logic e, input logic f);
        @(negedge clk);
        rst = r; slot_vld = s; deflect_req = d; sb_empty = e; sb_full = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1; slot_vld = '0; deflect_req = '0; sb_empty = 1'b1; sb_full = 1'b0;

        // single-cycle decisions from reset state (rr_ptr=0)
        vecs[0] = '{4'b1010, 4'b1010, 1'b1, 1'b0, eo(1'b1, 4'b0010, 1'b0, 4'b0, 1'b0, 4'b0,    1'b0)};
        vecs[1] = '{4'b1011, 4'b0000, 1'b0, 1'b0, eo(1'b0, 4'b0000, 1'b0, 4'b0, 1'b1, 4'b0100, 1'b0)};
        vecs[2] = '{4'b1111, 4'b0001, 1'b0, 1'b1, eo(1'b0, 4'b0000, 1'b0, 4'b0, 1'b0, 4'b0,    1'b0)};
        vecs[3] = '{4'b0000, 4'b0000, 1'b0, 1'b0, eo(1'b0, 4'b0000, 1'b0, 4'b0, 1'b1, 4'b0001, 1'b0)};
        vecs[4] = '{4'b1110, 4'b1000, 1'b0, 1'b0, eo(1'b1, 4'b1000, 1'b0, 4'b0, 1'b1, 4'b0001, 1'b0)};
        vecs[5] = '{4'b1100, 4'b1100, 1'b1, 1'b0, eo(1'b1, 4'b0100, 1'b0, 4'b0, 1'b0, 4'b0,    1'b0)};
        vecs[6] = '{4'b0000, 4'b0000, 1'b1, 1'b0, eo(1'b0, 4'b0000, 1'b0, 4'b0, 1'b0, 4'b0,    1'b0)};
        vecs[7] = '{4'b0111, 4'b0000, 1'b0, 1'b1, eo(1'b0, 4'b0000, 1'b0, 4'b0, 1'b1, 4'b1000, 1'b0)};

        // reset holds every output low even with a non-empty buffer and free slots
        drive(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("rst_outs_free", 32'(outs), 32'h0);
        drive(1'b1, 4'b1111, 4'b0001, 1'b0, 1'b0);
        chk("rst_outs_full", 32'(outs), 32'h0);
        tick();
        chk("rst_state", 32'(dut.state), 32'(NORMAL));
        chk("rst_cnt", 32'(dut.cnt), 32'd0);
        chk("rst_ptr", 32'(dut.rr_ptr), 32'd0);

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0);
            tick();
            drive(1'b0, vecs[i].slot, vecs[i].defl, vecs[i].empty, vecs[i].full);
            chk($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
        end

        // round-robin deflect advance
        drive(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 4'b1010, 4'b1010, 1'b1, 1'b0);
        chk("rr_first_sel", 32'(deflect_sel), 32'b0010);
        tick();
        chk("rr_first_ptr", 32'(dut.rr_ptr), 32'd2);
        drive(1'b0, 4'b1010, 4'b1010, 1'b1, 1'b0);
        chk("rr_second_sel", 32'(deflect_sel), 32'b1000);
        tick();
        chk("rr_second_ptr", 32'(dut.rr_ptr), 32'd0);

        // set rr_ptr=1, then inject, then starve with all slots busy
        drive(1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0);
        chk("ptr1_sel", 32'(deflect_sel), 32'b0001);
        tick();
        chk("ptr1", 32'(dut.rr_ptr), 32'd1);
        drive(1'b0, 4'b1011, 4'b0000, 1'b0, 1'b0);
        chk("inj_1011", 32'(outs), 32'(eo(1'b0, 4'b0, 1'b0, 4'b0, 1'b1, 4'b0100, 1'b0)));
        tick();
        chk("inj_cnt0", 32'(dut.cnt), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0);
            chk($sformatf("ramp_outs%0d", k), 32'(outs), 32'h0);
            tick();
            chk($sformatf("ramp_cnt%0d", k), 32'(dut.cnt), 32'(k));
        end
        chk("starve_state", 32'(dut.state), 32'(STARVE));

        // swap at rr_ptr=1
        drive(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0);
        chk("swap_outs", 32'(outs), 32'(eo(1'b0, 4'b0, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1)));
        tick();
        chk("swap_state", 32'(dut.state), 32'(COOL));
        chk("swap_ptr", 32'(dut.rr_ptr), 32'd2);
        chk("swap_cnt", 32'(dut.cnt), 32'd0);

        // two cool-down cycles with no redirect, then NORMAL
        drive(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0);
        chk("cool1_outs", 32'(outs), 32'h0);
        tick();
        chk("cool1_state", 32'(dut.state), 32'(COOL));
        drive(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0);
        chk("cool2_outs", 32'(outs), 32'h0);
        tick();
        chk("cool2_state", 32'(dut.state), 32'(NORMAL));
        chk("cool2_cnt", 32'(dut.cnt), 32'd2);

        // ramp back to STARVE (cnt 3..8)
        for (int k = 3; k <= 8; k++) begin
            drive(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0);
            tick();
        end
        chk("restarve_state", 32'(dut.state), 32'(STARVE));

        // full buffer blocks the swap; state holds
        drive(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1);
        chk("full_no_swap", 32'(outs), 32'(eo(1'b0, 4'b0, 1'b0, 4'b0, 1'b0, 4'b0, 1'b1)));
        tick();
        chk("full_state", 32'(dut.state), 32'(STARVE));
        chk("full_cnt_sat", 32'(dut.cnt), 32'd8);

        // deflect wins the write port in STARVE; no swap, stay STARVE
        drive(1'b0, 4'b1111, 4'b0100, 1'b0, 1'b0);
        chk("dfl_in_starve", 32'(outs), 32'(eo(1'b1, 4'b0100, 1'b0, 4'b0, 1'b0, 4'b0, 1'b1)));
        tick();
        chk("dfl_state", 32'(dut.state), 32'(STARVE));
        chk("dfl_ptr", 32'(dut.rr_ptr), 32'd3);

        // swap now picks slot 3 and the pointer wraps to 0
        drive(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0);
        chk("swap3_outs", 32'(outs), 32'(eo(1'b0, 4'b0, 1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1)));
        tick();
        chk("swap3_ptr", 32'(dut.rr_ptr), 32'd0);
        chk("swap3_state", 32'(dut.state), 32'(COOL));

        // reset mid-operation drops grants in the same cycle
        drive(1'b1, 4'b1011, 4'b0001, 1'b0, 1'b0);
        chk("midrst_outs", 32'(outs), 32'h0);
        tick();
        chk("midrst_state", 32'(dut.state), 32'(NORMAL));
        chk("midrst_cnt", 32'(dut.cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
